add_serial_driver: RTL and testbench



---
 rtl/add_serial_pkg.sv | 23 ++
 rtl/add_serial_driver_if.sv | 30 +++
 rtl/add_serial_latency_ctr.sv | 29 ++
 rtl/add_serial_driver.sv | 109 ++++++++++
 tb/tb_add_serial_driver.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/add_serial_pkg.sv
// Shared types and constants for the add_serial driver slice.
// Adder timing: one delay cycle followed by one ADD cycle per bit.
package add_serial_pkg;

    localparam int unsigned WIDTH = 8;

    // The adder inverts these input bits internally.
    localparam logic [WIDTH-1:0] MASK_A = 8'hC5;
    localparam logic [WIDTH-1:0] MASK_B = 8'h3C;

    localparam int unsigned ADD_DELAY_CYC = 1;
    localparam int unsigned ADD_BIT_CYC   = WIDTH;
    localparam int unsigned ADD_LAT       = ADD_DELAY_CYC + ADD_BIT_CYC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REARM,
        S_LAUNCH,
        S_WAIT,
        S_HOLD
    } drv_state_t;

endpackage

// File: rtl/add_serial_driver_if.sv
// Operand stream, adder side-band and result stream of the add_serial driver.
// master: the environment (operand source, adder, result consumer).
// slave:  the driver itself.
interface add_serial_driver_if;
    import add_serial_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_en;
    logic [WIDTH-1:0] add_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, add_out, res_ready,
        input  in_ready, add_a, add_b, add_en, res_valid, res_sum, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, add_out, res_ready,
        output in_ready, add_a, add_b, add_en, res_valid, res_sum, busy
    );

endinterface

// File: rtl/add_serial_latency_ctr.sv
// Loadable down-counter: load sets the count, en counts down to zero,
// done pulses on an enabled cycle that finds the count at zero.
module add_serial_latency_ctr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    // Count register: load wins over decrement, saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = en && !load && (count == '0);

endmodule

// File: rtl/add_serial_driver.sv
// Issue stage and result capture for the add_serial serial adder.
// Optional feature macro: ADD_PRESCRAMBLE_EN -- XOR operands with the
// adder's inversion masks so res_sum is the plain sum mod 2^WIDTH.
module add_serial_driver
    import add_serial_pkg::*;
#(
    parameter int unsigned      WIDTH       = add_serial_pkg::WIDTH,
    parameter int unsigned      CAPTURE_LAT = add_serial_pkg::ADD_LAT + 1,
    parameter logic [WIDTH-1:0] MASK_A      = add_serial_pkg::MASK_A,
    parameter logic [WIDTH-1:0] MASK_B      = add_serial_pkg::MASK_B
) (
    input  logic                clk,
    input  logic                rst,
    add_serial_driver_if.slave  bus
);

`ifdef ADD_PRESCRAMBLE_EN
    localparam bit PRESCRAMBLE = 1'b1;
`else
    localparam bit PRESCRAMBLE = 1'b0;
`endif

    localparam logic [WIDTH-1:0] ISSUE_MASK_A = PRESCRAMBLE ? MASK_A : '0;
    localparam logic [WIDTH-1:0] ISSUE_MASK_B = PRESCRAMBLE ? MASK_B : '0;
    localparam int unsigned      CTR_W        = (CAPTURE_LAT > 2) ? $clog2(CAPTURE_LAT) : 1;

    drv_state_t       state;
    logic             armed;
    logic             ctr_load;
    logic             ctr_en;
    logic             ctr_done;
    logic [WIDTH-1:0] a_issue;
    logic [WIDTH-1:0] b_issue;

    assign a_issue  = bus.in_a ^ ISSUE_MASK_A;
    assign b_issue  = bus.in_b ^ ISSUE_MASK_B;
    assign bus.busy = (state != S_IDLE);

    // Loaded on the launch edge with CAPTURE_LAT-1 so the zero count is
    // reached on the edge CAPTURE_LAT cycles after launch.
    assign ctr_load = (state == S_LAUNCH);
    assign ctr_en   = (state == S_WAIT);

    add_serial_latency_ctr #(
        .W (CTR_W)
    ) u_lat_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (CTR_W'(CAPTURE_LAT - 1)),
        .en       (ctr_en),
        .done     (ctr_done)
    );

    // Issue/capture FSM with registered handshake and adder outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            armed         <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.add_en    <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_sum   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        bus.in_ready <= 1'b0;
                        bus.add_a    <= a_issue;
                        bus.add_b    <= b_issue;
                        bus.add_en   <= 1'b1;
                        // A finished adder sits in DONE and needs one en to return to IDLE.
                        state        <= armed ? S_REARM : S_LAUNCH;
                    end
                end
                S_REARM: begin
                    bus.add_en <= 1'b1;
                    state      <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    bus.add_en <= 1'b0;
                    armed      <= 1'b1;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (ctr_done) begin
                        bus.res_sum   <= bus.add_out;
                        bus.res_valid <= 1'b1;
                        state         <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_serial_driver.sv
// Directed bench for add_serial_driver with a behavioural add_serial adder.
// Expected sums come from hand-computed tables for both settings of
// ADD_PRESCRAMBLE_EN.
module tb_add_serial_driver;
    import add_serial_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_serial_driver_if bus ();

    add_serial_driver #(
        .CAPTURE_LAT (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural adder: en in IDLE loads inverted operands, one delay
    // cycle, then one sum bit per cycle LSB first, then DONE until en.
    typedef enum logic [1:0] {M_IDLE, M_DLY, M_ADD, M_DONE} m_state_t;
    m_state_t   m_st;
    logic [7:0] m_a, m_b, m_out;
    logic [2:0] m_bit;
    logic       m_c;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st <= M_IDLE; m_a <= '0; m_b <= '0; m_out <= '0; m_bit <= '0; m_c <= 1'b0;
        end else begin
            case (m_st)
                M_IDLE: if (bus.add_en) begin
                    m_a <= bus.add_a ^ 8'hC5;
                    m_b <= bus.add_b ^ 8'h3C;
                    m_out <= '0; m_bit <= '0; m_c <= 1'b0;
                    m_st <= M_DLY;
                end
                M_DLY: m_st <= M_ADD;
                M_ADD: begin
                    m_out[m_bit] <= m_a[m_bit] ^ m_b[m_bit] ^ m_c;
                    m_c <= (m_a[m_bit] & m_b[m_bit]) | (m_c & (m_a[m_bit] ^ m_b[m_bit]));
                    m_bit <= m_bit + 3'd1;
                    if (m_bit == 3'd7) m_st <= M_DONE;
                end
                M_DONE: if (bus.add_en) m_st <= M_IDLE;
                default: m_st <= M_IDLE;
            endcase
        end
    end

    assign bus.add_out = m_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pick(input logic [7:0] on_v, input logic [7:0] off_v);
`ifdef ADD_PRESCRAMBLE_EN
        return on_v;
`else
        return off_v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 40 && !bus.in_ready; k++) tick();
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    // One transaction: accept, count en cycles up to res_valid, hold off
    // res_ready for 'hold' cycles, then consume.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_sum, input int exp_lat,
                          input int exp_en, input int hold);
        int   acc;
        int   en_cnt;
        logic got;
        bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
        wait_ready(tag);
        tick();
        acc = cyc;
        bus.in_valid = 1'b0;
        check({tag, ".add_a"}, 32'(bus.add_a), 32'(a ^ pick(8'hC5, 8'h00)));
        check({tag, ".add_b"}, 32'(bus.add_b), 32'(b ^ pick(8'h3C, 8'h00)));
        en_cnt = 0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.add_en) en_cnt++;
            if (bus.res_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check({tag, ".res_valid"}, 32'(got), 32'd1);
        check({tag, ".latency"}, 32'(cyc - acc), 32'(exp_lat));
        check({tag, ".en_cycles"}, 32'(en_cnt), 32'(exp_en));
        check({tag, ".res_sum"}, 32'(bus.res_sum), 32'(exp_sum));
        for (int k = 0; k < hold; k++) begin
            tick();
            check($sformatf("%s.hold%0d", tag, k),
                  32'({bus.res_valid, bus.in_ready, bus.add_en, bus.res_sum}),
                  32'({1'b1, 1'b0, 1'b0, exp_sum}));
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({tag, ".after_hs"}, 32'({bus.res_valid, bus.in_ready, bus.busy}), 32'b010);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sa [4];
        logic [7:0] sb [4];
        logic [7:0] se [4];
        int         acc_s [4];
        logic       got;

        sa[0] = 8'h01; sb[0] = 8'h02; se[0] = pick(8'h03, 8'h02);
        sa[1] = 8'h03; sb[1] = 8'h04; se[1] = pick(8'h07, 8'hFE);
        sa[2] = 8'h80; sb[2] = 8'h80; se[2] = pick(8'h00, 8'h01);
        sa[3] = 8'h7F; sb[3] = 8'h01; se[3] = pick(8'h80, 8'hF7);

        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;

        // Reset values.
        repeat (2) tick();
        check("rst.ctrl", 32'({bus.in_ready, bus.add_en, bus.res_valid, bus.busy}), 32'd0);
        check("rst.data", 32'({bus.add_a, bus.add_b, bus.res_sum}), 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("rst.in_ready_up", 32'(bus.in_ready), 32'd1);

        // First op after reset: no re-arm; later ops re-arm the adder.
        run_op("op1", 8'h05, 8'h03, pick(8'h08, 8'hFF), 11, 1, 0);
        run_op("op2", 8'hFF, 8'h01, pick(8'h00, 8'h77), 12, 2, 0);
        run_op("bp",  8'h12, 8'h34, pick(8'h46, 8'hDF), 12, 2, 5);

        // Reset in S_WAIT at t0+4 (t0 = accept+2 on the re-arm path).
        bus.in_a = 8'h10; bus.in_b = 8'h20; bus.in_valid = 1'b1;
        wait_ready("midrst");
        tick();
        bus.in_valid = 1'b0;
        repeat (6) tick();
        check("midrst.busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst.ctrl", 32'({bus.in_ready, bus.add_en, bus.res_valid, bus.busy}), 32'd0);
        check("midrst.data", 32'({bus.add_a, bus.add_b, bus.res_sum}), 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        run_op("post_rst", 8'h10, 8'h20, pick(8'h30, 8'hF1), 11, 1, 0);
        run_op("zero",     8'h00, 8'h00, pick(8'h00, 8'h01), 12, 2, 0);

        // Streaming: in_valid and res_ready held high across four ops.
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk) rst = 1'b0;
        tick();
        bus.res_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_a = sa[i]; bus.in_b = sb[i];
            wait_ready($sformatf("stream%0d", i));
            tick();
            acc_s[i] = cyc;
            if (i == 3) bus.in_valid = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (bus.res_valid) begin
                    got = 1'b1;
                    break;
                end
                tick();
            end
            check($sformatf("stream%0d.res_valid", i), 32'(got), 32'd1);
            check($sformatf("stream%0d.res_sum", i), 32'(bus.res_sum), 32'(se[i]));
        end
        check("stream.spacing01", 32'(acc_s[1] - acc_s[0]), 32'd13);
        tick();
        check("stream.idle_end", 32'({bus.res_valid, bus.busy}), 32'd0);
        bus.res_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
